// File: rtl/match_event_counter.sv
// match_event_counter
//
// First clocked stage after the combinational 4-bit constant comparator.
// Debounces the comparator's match level, emits one pulse per qualified
// match event, counts events in a saturating counter and raises a sticky
// alarm when the count reaches ALARM_TH. ack clears both count and alarm.
//
// Optional feature (macro MATCH_EVENT_SYNC_EN):
//   defined   - q_in goes through a 2-flop synchronizer (reset to 0) before
//               the FSM; every latency grows by 2 cycles.
//   undefined - q_in feeds the FSM directly and must be synchronous to clk.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   q_in         match level from the comparator
//   en           enable; low forces the FSM back to IDLE
//   ack          alarm acknowledge; clears alarm and count
//   match_valid  high while the FSM is in MATCHED
//   match_pulse  one-cycle pulse on entry to MATCHED
//   count        qualified events since reset or the last ack (saturating)
//   alarm        sticky, set when count reaches ALARM_TH
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | match level low (or disabled), waiting for a high sample
// QUALIFY | counting consecutive high samples, deb_cnt holds the tally
// MATCHED | event qualified; held until the match level drops

module match_event_counter #(
    parameter int DEB_CYCLES = 3,
    parameter int CNT_W      = 8,
    parameter int ALARM_TH   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             q_in,
    input  logic             en,
    input  logic             ack,
    output logic             match_valid,
    output logic             match_pulse,
    output logic [CNT_W-1:0] count,
    output logic             alarm
);

    localparam int DEB_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUALIFY = 2'd1,
        MATCHED = 2'd2
    } state_t;

    state_t             state;
    logic [DEB_W-1:0]   deb_cnt;
    logic               q_s;
    logic               enter_match;
    logic [CNT_W-1:0]   count_base;
    logic [CNT_W-1:0]   count_next;
    logic               alarm_next;

`ifdef MATCH_EVENT_SYNC_EN
    logic sync_ff1;
    logic sync_ff2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_ff1 <= 1'b0;
            sync_ff2 <= 1'b0;
        end else begin
            sync_ff1 <= q_in;
            sync_ff2 <= sync_ff1;
        end
    end

    assign q_s = sync_ff2;
`else
    assign q_s = q_in;
`endif

    // deb_cnt counts high samples already taken, so the sample being taken
    // now is number deb_cnt+1; entry happens when that equals DEB_CYCLES.
    always_comb begin
        enter_match = 1'b0;
        if (en && q_s) begin
            case (state)
                IDLE:    enter_match = (DEB_CYCLES == 1);
                QUALIFY: enter_match = (deb_cnt == DEB_W'(DEB_CYCLES - 1));
                default: enter_match = 1'b0;
            endcase
        end
    end

    // ack wins over the held count, but an event on the same edge still lands.
    always_comb begin
        count_base = ack ? '0 : count;
        count_next = count_base;
        if (enter_match && (count_base != {CNT_W{1'b1}}))
            count_next = count_base + CNT_W'(1);
        alarm_next = (alarm & ~ack) | (count_next == CNT_W'(ALARM_TH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            deb_cnt     <= '0;
            match_valid <= 1'b0;
            match_pulse <= 1'b0;
            count       <= '0;
            alarm       <= 1'b0;
        end else begin
            count       <= count_next;
            alarm       <= alarm_next;
            match_pulse <= enter_match;
            if (!en) begin
                state       <= IDLE;
                deb_cnt     <= '0;
                match_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (q_s) begin
                            if (enter_match) begin
                                state       <= MATCHED;
                                deb_cnt     <= '0;
                                match_valid <= 1'b1;
                            end else begin
                                state   <= QUALIFY;
                                deb_cnt <= DEB_W'(1);
                            end
                        end
                    end
                    QUALIFY: begin
                        if (!q_s) begin
                            state   <= IDLE;
                            deb_cnt <= '0;
                        end else if (enter_match) begin
                            state       <= MATCHED;
                            deb_cnt     <= '0;
                            match_valid <= 1'b1;
                        end else begin
                            deb_cnt <= deb_cnt + DEB_W'(1);
                        end
                    end
                    MATCHED: begin
                        if (!q_s) begin
                            state       <= IDLE;
                            match_valid <= 1'b0;
                        end
                    end
                    default: begin
                        state       <= IDLE;
                        deb_cnt     <= '0;
                        match_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_match_event_counter.sv
module tb_match_event_counter;

`ifdef MATCH_EVENT_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    logic       clk;
    logic       rst;
    logic       q_in;
    logic       en;
    logic       ack;
    logic       match_valid;
    logic       match_pulse;
    logic [7:0] count;
    logic       alarm;
    logic       s_match_valid;
    logic       s_match_pulse;
    logic [3:0] s_count;
    logic       s_alarm;

    int total_checks = 0;
    int fail_checks  = 0;

    match_event_counter #(.DEB_CYCLES(3), .CNT_W(8), .ALARM_TH(10)) dut (
        .clk(clk), .rst(rst), .q_in(q_in), .en(en), .ack(ack),
        .match_valid(match_valid), .match_pulse(match_pulse),
        .count(count), .alarm(alarm)
    );

    match_event_counter #(.DEB_CYCLES(3), .CNT_W(4), .ALARM_TH(15)) dut_sat (
        .clk(clk), .rst(rst), .q_in(q_in), .en(en), .ack(ack),
        .match_valid(s_match_valid), .match_pulse(s_match_pulse),
        .count(s_count), .alarm(s_alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_checks++;
        assert (obs === exp) else begin
            fail_checks++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive inputs, let one rising edge sample them, settle 1 time unit.
    task automatic step(input logic qv, input logic env, input logic ackv);
        q_in = qv;
        en   = env;
        ack  = ackv;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0);
    endtask

    task automatic one_event();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        rst  = 1'b1;
        q_in = 1'b0;
        en   = 1'b0;
        ack  = 1'b0;
        #12;
        chk("reset_valid", match_valid, 0);
        chk("reset_pulse", match_pulse, 0);
        chk("reset_count", count, 0);
        chk("reset_alarm", alarm, 0);
        rst = 1'b0;
        idle(2);

        // Debounce: match_pulse only on the DEB_CYCLES-th high edge (+SL).
        for (int i = 1; i <= 3 + SL; i++) begin
            step(1'b1, 1'b1, 1'b0);
            chk($sformatf("deb_pulse_e%0d", i), match_pulse, (i == 3 + SL) ? 1 : 0);
            chk($sformatf("deb_valid_e%0d", i), match_valid, (i == 3 + SL) ? 1 : 0);
        end
        chk("deb_count", count, 1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0);
            chk("deb_hold_pulse", match_pulse, 0);
            chk("deb_hold_valid", match_valid, 1);
        end
        chk("deb_hold_count", count, 1);
        for (int i = 0; i < SL; i++) begin
            step(1'b0, 1'b1, 1'b0);
            chk("deb_drop_lag_valid", match_valid, 1);
        end
        step(1'b0, 1'b1, 1'b0);
        chk("deb_drop_valid", match_valid, 0);
        chk("deb_drop_count", count, 1);

        // Clear count, then glitch reject: 1,1,0,1,1,0.
        step(1'b0, 1'b1, 1'b1);
        chk("ack_clear_count", count, 0);
        begin
            logic [5:0] pat;
            pat = 6'b011011;
            for (int i = 0; i < 6 + SL; i++) begin
                step((i < 6) ? pat[i] : 1'b0, 1'b1, 1'b0);
                chk("glitch_pulse", match_pulse, 0);
                chk("glitch_valid", match_valid, 0);
            end
        end
        chk("glitch_count", count, 0);

        // Ten events -> alarm at count 10.
        for (int e = 1; e <= 10; e++) begin
            one_event();
            if (e == 9) begin
                idle(SL);
                chk("ev9_count", count, 9);
                chk("ev9_alarm", alarm, 0);
            end
        end
        idle(SL);
        chk("ev10_count", count, 10);
        chk("ev10_alarm", alarm, 1);
        idle(3);
        chk("ev10_alarm_sticky", alarm, 1);

        step(1'b0, 1'b1, 1'b1);
        chk("ack_alarm", alarm, 0);
        chk("ack_count", count, 0);

        // ack on the same edge as an event entry.
        one_event();
        one_event();
        idle(SL);
        chk("pre_ackev_count", count, 2);
        for (int i = 0; i < 2 + SL; i++) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("ackev_pulse", match_pulse, 1);
        chk("ackev_count", count, 1);
        chk("ackev_alarm", alarm, 0);
        idle(1 + SL);

        // en low during the 2nd high sample of QUALIFY kills the event.
        step(1'b1, 1'b1, 1'b0);
        chk("en_pulse_a", match_pulse, 0);
        for (int i = 0; i < 1 + SL; i++) begin
            step(1'b1, 1'b0, 1'b0);
            chk("en_pulse_b", match_pulse, 0);
            chk("en_valid_b", match_valid, 0);
        end
        for (int i = 0; i < 1 + SL; i++) begin
            step(1'b0, 1'b1, 1'b0);
            chk("en_pulse_c", match_pulse, 0);
        end
        chk("en_count_hold", count, 1);

        // Async reset in the middle of MATCHED.
        for (int i = 0; i < 3 + SL; i++) step(1'b1, 1'b1, 1'b0);
        chk("pre_rst_valid", match_valid, 1);
        chk("pre_rst_count", count, 2);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", match_valid, 0);
        chk("async_rst_pulse", match_pulse, 0);
        chk("async_rst_count", count, 0);
        #20;
        rst = 1'b0;
        idle(2);

        // Saturation (4-bit instance, ALARM_TH=15); 8-bit instance keeps counting.
        for (int e = 1; e <= 17; e++) begin
            one_event();
            if (e == 14) begin
                idle(SL);
                chk("sat14_count", s_count, 14);
                chk("sat14_alarm", s_alarm, 0);
            end
            if (e == 15) begin
                idle(SL);
                chk("sat15_count", s_count, 15);
                chk("sat15_alarm", s_alarm, 1);
            end
        end
        idle(SL);
        chk("sat17_count", s_count, 15);
        chk("sat17_alarm", s_alarm, 1);
        chk("wide17_count", count, 17);
        chk("wide17_alarm", alarm, 1);
        step(1'b0, 1'b1, 1'b1);
        chk("sat_ack_count", s_count, 0);
        chk("sat_ack_alarm", s_alarm, 0);

        $display("%0d/%0d checks passed", total_checks - fail_checks, total_checks);
        $finish;
    end

endmodule
